// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and word geometry.
// The BOOT_LOADER_CHECKSUM_EN macro (see boot_loader.sv) enables the CHK state.
package boot_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CHK  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Byte source may push only while the image is still being collected.
    function automatic logic accepts_bytes(input state_t s);
        logic r;
        case (s)
            ST_HDR:  r = 1'b1;
            ST_DATA: r = 1'b1;
            ST_CHK:  r = 1'b1;
            ST_DONE: r = 1'b0;
            ST_ERR:  r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/boot_loader_byte_to_word.sv
// Little-endian byte-to-word assembler: first byte lands in bits [7:0].
// word/word_valid present the completed word in the same cycle its 4th byte is taken.
module byte_to_word
    import boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_byte,
    input  logic              in_take,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0]        cnt_r;
    logic [WORD_W-9:0] shift_r;

    // Byte counter and shift register holding the three earlier bytes of the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 2'd0;
            shift_r <= '0;
        end else if (in_take) begin
            cnt_r   <= cnt_r + 2'd1;
            shift_r <= {in_byte, shift_r[WORD_W-9:8]};
        end
    end

    assign word       = {in_byte, shift_r};
    assign word_valid = in_take && (cnt_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed little-endian image into instruction memory and releases the core.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing modulo-2^32 sum of the data words.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset_n,
    output logic        load_done,
    output logic        load_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = ST_CHK;
`else
    localparam state_t AFTER_DATA = ST_DONE;
`endif

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   count_r;
    logic               accept_s;
    logic               word_valid_s;
    logic [WORD_W-1:0]  word_s;
    logic               write_s;
    logic               last_word_s;

    assign accept_s    = in_valid && in_ready;
    assign last_word_s = (idx_r + IDX_W'(1)) == count_r;

    byte_to_word u_b2w (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (in_data),
        .in_take    (accept_s),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_r;

    // Running modulo-2^32 sum of every data word written.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r <= '0;
        end else if (write_s) begin
            sum_r <= sum_r + word_s;
        end
    end
`endif

    // Next-state decode; a word write is issued for each completed DATA word.
    always_comb begin
        state_next_s = state_r;
        write_s      = 1'b0;
        case (state_r)
            ST_HDR: begin
                if (word_valid_s) begin
                    if (word_s > 32'(DEPTH_WORDS)) begin
                        state_next_s = ST_ERR;
                    end else if (word_s == 32'd0) begin
                        state_next_s = AFTER_DATA;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (word_valid_s) begin
                    write_s = 1'b1;
                    if (last_word_s) begin
                        state_next_s = AFTER_DATA;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (word_valid_s) begin
                    if (word_s == sum_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = ST_CHK;
                end
            end
`endif
            ST_DONE: state_next_s = ST_DONE;
            ST_ERR:  state_next_s = ST_ERR;
            default: state_next_s = ST_ERR;
        endcase
    end

    // State, word index and all registered outputs; status follows the next state so it
    // changes on the edge that accepts the final byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HDR;
            idx_r       <= '0;
            count_r     <= '0;
            in_ready    <= 1'b1;
            imem_we     <= 1'b0;
            imem_addr   <= ADDR_BASE;
            imem_wdata  <= '0;
            cpu_reset_n <= 1'b0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready    <= accepts_bytes(state_next_s);
            imem_we     <= write_s;
            cpu_reset_n <= (state_next_s == ST_DONE);
            load_done   <= (state_next_s == ST_DONE);
            load_error  <= (state_next_s == ST_ERR);
            if (write_s) begin
                imem_addr  <= ADDR_BASE + (32'(idx_r) << 2);
                imem_wdata <= word_s;
                idx_r      <= idx_r + IDX_W'(1);
            end
            // Oversized counts go to ERR, so the truncation here only sees legal N.
            if ((state_r == ST_HDR) && word_valid_s) begin
                count_r <= word_s[IDX_W-1:0];
            end
        end
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Streams a program image from a byte source (UART receiver or bench driver) into instruction memory and holds the `riscV` core in reset until the image is complete. Sits directly upstream of `instruction_memory` (drives its write port) and gates the core's `reset_n`. After a successful load it releases the core and refuses further bytes until reset.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: instruction memory capacity in 32-bit words.
- `ADDR_BASE`, 32'h0000_0000: byte address of the first loaded word.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high; one clock, synchronous active-high reset (fixed).
- `in_data` input 8: image byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: one-cycle write strobe to instruction memory.
- `imem_addr` output 32: word-aligned byte address of the write.
- `imem_wdata` output 32: word being written.
- `cpu_reset_n` output 1: active-low reset to the core; 0 until load completes.
- `load_done` output 1: image loaded, core released.
- `load_error` output 1: image rejected, core held.

## Operation
- Handshake: a byte transfers on a rising edge where `in_valid && in_ready`. `in_valid` may drop at any time, with no timeout.
- Image format is little-endian throughout: a 4-byte word count N, then N words of 4 bytes each, then (checksum build only) a 4-byte checksum.
- States:
  - HDR: collect 4 bytes of N. After the 4th byte:
    - N > `DEPTH_WORDS` → ERR.
    - N == 0 → CHK (checksum build) or DONE.
    - otherwise → DATA.
  - DATA: a byte counter 0..3 shifts bytes into a word assembler. On the 4th byte, write word index i (0..N-1) and increment i. After word N-1 → CHK or DONE.
  - CHK: collect 4 bytes. On the 4th byte, match → DONE, mismatch → ERR.
  - DONE: `in_ready`=0, `cpu_reset_n`=1, `load_done`=1. Terminal until reset.
  - ERR: `in_ready`=0, `cpu_reset_n`=0, `load_error`=1. Terminal until reset.
- `in_ready` = 1 in HDR, DATA and CHK.
- Write address: `imem_addr` = `ADDR_BASE` + 4*i, computed modulo 2^32. i is `$clog2(DEPTH_WORDS+1)` bits wide and never exceeds N.
- Reset mid-load: every state, counter and the assembler clear. Words already written stay in memory. The core remains held.

## Timing
- Reset values:
  - `in_ready`=1, `imem_we`=0, `imem_addr`=`ADDR_BASE`, `imem_wdata`=0.
  - `cpu_reset_n`=0, `load_done`=0, `load_error`=0.
  - state=HDR, all counters 0.
- `imem_we` is registered. It pulses high for exactly the one cycle after the edge that accepts a word's 4th byte, with `imem_addr`/`imem_wdata` stable during that cycle.
- Back-to-back bytes are accepted every cycle. The minimum spacing between write strobes is 4 cycles.
- `cpu_reset_n`, `load_done` and `load_error` are registered. They change on the edge after the final byte is accepted, and that same edge drops `in_ready`.
- The last `imem_we` pulse and `cpu_reset_n` rising occur on the same cycle. The memory write lands before the core's first fetch edge.

## Configuration
- `BOOT_LOADER_CHECKSUM_EN` defined:
  - CHK state and a 32-bit running sum are present.
  - The sum is the modulo-2^32 addition of all N data words.
  - The trailing word must equal the sum, otherwise → ERR.
- Undefined: no CHK state, no sum logic, and no trailing word is consumed. `load_error` arises only from N > `DEPTH_WORDS`.

## Structure
- Shared package `boot_loader_pkg`:
  - state enum (HDR, DATA, CHK, DONE, ERR).
  - `WORD_W`=32 and `BYTES_PER_WORD`=4.
- One sub-module, `byte_to_word`: 2-bit byte counter, shift register and `word_valid` pulse. Reused by HDR, DATA and CHK.

## Test plan
- N=2, words 32'h0000_0093, 32'h0010_0113, bytes every cycle, no checksum → writes addr 0 and 4 with those values. `cpu_reset_n` rises on the cycle of the second write, then `in_ready`=0.
- Same image with `in_valid` toggled 1/0 each cycle → identical writes, spacing 8 cycles, same final state.
- N=0 (checksum build with trailing sum 0) → no `imem_we`; `load_done`=1 one cycle after the last byte.
- N=`DEPTH_WORDS`+1 → `load_error`=1 after the 4th header byte, no writes, `cpu_reset_n` stays 0.
- Checksum build, N=1, word 32'hFFFF_FFFF, checksum 32'hFFFF_FFFE → ERR. Checksum 32'hFFFF_FFFF → DONE.
- `reset` asserted after the 6th byte of a 3-word load → all outputs at reset values next cycle. A fresh full image then loads correctly from address `ADDR_BASE`.
